// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  // Default operand/result width in bits.
  localparam int WIDTH_DEFAULT = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder; the serial adder reuses it for every bit.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are captured on start and summed LSB first,
// one bit per clock, through a single full adder cell.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
// the operation into a - b (B inverted, carry-in forced to 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_c_out;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_load;
  logic             w_s;
  logic             w_cout;

  // Operand B and the initial carry as they are loaded on the accepting edge.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load     = sub ? ~b : b;
  assign w_carry_load = sub ? 1'b1 : c_in;
`else
  assign w_b_load     = b;
  assign w_carry_load = c_in;
`endif

  full_adder_cell u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // Sequencer: accept operands, shift one bit per clock, publish the result.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, exactly like the flops it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_carry_load;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not looked at here: operands stay frozen.
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cout;
          r_res   <= {w_s, r_res[WIDTH-1:1]};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            r_sum   <= {w_s, r_res[WIDTH-1:1]};
            r_c_out <= w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_c_out;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port start  input  1  request to begin an addition; sampled only in IDLE or DONE.
REQ-005 SHALL provide port a  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 SHALL provide port b  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 SHALL provide port c_in  input  1  carry-in, captured on the accepting edge.
REQ-008 SHALL provide port busy  output  1  high while bits are being processed.
REQ-009 SHALL provide port done  output  1  single-cycle pulse marking result valid.
REQ-010 SHALL provide port sum  output  WIDTH  result, held stable between done pulses.
REQ-011 SHALL provide port c_out  output  1  final carry, held with sum.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE/DONE with start=1 at an edge SHALL load A/B shift registers, load carry register with c_in, clear bit counter, enter RUN.
REQ-014 RUN SHALL process one bit per clock, LSB first: bit = a0^b0^carry, carry = majority(a0,b0,carry); bit shifted into result MSB, operands shifted right.
REQ-015 RUN SHALL last exactly WIDTH clocks, then enter DONE; bit counter width = clog2(WIDTH)+1, no wrap.
REQ-016 Latency: start high in cycle 0 -> busy high cycles 1..WIDTH -> done high in cycle WIDTH+1 only.
REQ-017 sum and c_out SHALL update only on the edge entering DONE and hold until the next completion or reset.
REQ-018 start while busy SHALL be ignored; operands are not re-sampled.
REQ-019 start high during DONE SHALL be accepted (back-to-back), busy rising next cycle; done still pulses one cycle.
REQ-020 DONE with start low SHALL return to IDLE after one cycle.
REQ-021 sum/c_out SHALL equal (a + b + c_in) mod 2^(WIDTH+1), split as {c_out,sum}.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, c_out=0, clear shift/carry/counter regs.
REQ-023 rst SHALL take priority over start and over RUN progress; reset mid-RUN aborts with no done pulse.

Configuration
REQ-024 Macro SERIAL_ADDER_SUB_EN defined SHALL add port sub  input  1, captured with operands.
REQ-025 With SERIAL_ADDER_SUB_EN and sub=1: B loaded inverted, carry loaded 1 (c_in ignored); result = a - b mod 2^WIDTH, c_out = 1 when no borrow.
REQ-026 Without SERIAL_ADDER_SUB_EN: no sub port, add-only behaviour per REQ-021.

Structure
REQ-027 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the WIDTH default constant.
REQ-028 One sub-module full_adder_cell (1-bit combinational a,b,cin -> s,cout) SHALL compute each bit; instantiated once.

Verification
REQ-029 WIDTH=8, a=0x0F b=0x01 c_in=0 start pulse cycle 0 -> busy cycles 1..8, done cycle 9, sum=0x10 c_out=0.
REQ-030 a=0xFF b=0x01 c_in=0 -> sum=0x00 c_out=1; a=0xFF b=0xFF c_in=1 -> sum=0xFF c_out=1.
REQ-031 Start with a=0x01 b=0x01, then start with a=0x80 b=0x80 in cycle 3 -> ignored, result sum=0x02 c_out=0.
REQ-032 rst=1 in cycle 4 of RUN -> next cycle busy=0 done=0 sum=0 c_out=0, no done for aborted op.
REQ-033 start held high through done cycle with new operands a=0x10 b=0x20 -> second done exactly WIDTH+1 cycles after first, sum=0x30.
REQ-034 WIDTH=2 exhaustive loop over {c_in,b,a} = 0..31 (with SERIAL_ADDER_SUB_EN: a=0x05 b=0x07 sub=1 at WIDTH=8 -> sum=0xFE c_out=0) -> every result matches REQ-021/REQ-025.
